camera_capture_sched: RTL

Capture sequencer in front of the camera capture block, the single Camera Link capture path shared by the Hawk and Owl sensors. It takes capture requests from two requesters, picks one by round-robin arbitration, and drives the camera select line. When the select changes, it waits out the path's reset/relock interval. It then issues a one-cycle capture pulse, tracks the capture through `camera_in_progress`, and reports completion or start timeout per requester. Everything runs in the `sys_clk` domain, between software control registers and the capture block.

---
 rtl/camera_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 18 +
 rtl/camera_capture_sched.sv | 126 ++++++++++++
 3 files changed

// File: rtl/camera_pkg.sv
// Shared types and constants for the camera capture sequencer.
// The settle default is twice the capture path's internal reset, which leaves relock margin.
package camera_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    LOCK_WAIT,
    ARM,
    WAIT_START,
    WAIT_END,
    DONE
  } sched_state_e;

  typedef enum logic {
    HAWK = 1'b0,
    OWL  = 1'b1
  } cam_sel_e;

  localparam int CAM_PATH_RST_CYCLES = 8;
  localparam int SETTLE_CYCLES_DFLT  = 2 * CAM_PATH_RST_CYCLES;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, combinational, zero latency.
// On a tie the camera that was not served last wins; pend[0] is Hawk and pend[1] is Owl.
module rr_arb2
  import camera_pkg::*;
(
  input  logic     [1:0] pend,
  input  cam_sel_e       last_srv,
  output logic     [1:0] gnt_oh
);

  always_comb begin
    gnt_oh = pend;
    if (pend == 2'b11) begin
      gnt_oh = (last_srv == OWL) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/camera_capture_sched.sv
// Capture sequencer: arbitrates Hawk/Owl requests, settles the select, strobes one capture per grant.
// Request to strobe is 3 cycles, plus SETTLE_CYCLES on a select change; all outputs are registered.
module camera_capture_sched
  import camera_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DFLT,
  parameter int CNT_W         = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             req_hawk,
  input  logic             req_owl,
  input  logic             abort,
  input  logic [31:0]      start_timeout,
  input  logic             serde_locked,
  input  logic             camera_in_progress,
  output logic             camera_sel,
  output logic             new_capture,
  output logic             busy,
  output logic             done_hawk,
  output logic             done_owl,
  output logic             err_timeout,
  output logic             err_sel,
  output logic [CNT_W-1:0] frame_cnt_hawk,
  output logic [CNT_W-1:0] frame_cnt_owl
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  sched_state_e  state;
  sched_state_e  state_nx;
  logic          pend_h;
  logic          pend_o;
  cam_sel_e      last_srv;
  cam_sel_e      gnt;
  cam_sel_e      gnt_pick;
  logic [1:0]    gnt_oh;
  logic          grant_vld;
  logic          timeout_hit;
  logic          done_fire;
  logic [SW-1:0] settle_cnt;
  logic [31:0]   to_cnt;

  rr_arb2 u_arb (
    .pend     ({pend_o, pend_h}),
    .last_srv (last_srv),
    .gnt_oh   (gnt_oh)
  );

  assign gnt_pick    = gnt_oh[1] ? OWL : HAWK;
  assign grant_vld   = (state == IDLE) && !abort && (gnt_oh != 2'b00);
  assign timeout_hit = (state == WAIT_START) && !abort && !camera_in_progress
                       && (to_cnt == start_timeout);
  assign done_fire   = (state == DONE) && !abort;

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:       if (grant_vld) state_nx = (gnt_pick != camera_sel) ? SETTLE : LOCK_WAIT;
        SETTLE:     if (settle_cnt == SETTLE_LAST) state_nx = LOCK_WAIT;
        LOCK_WAIT:  if (serde_locked) state_nx = ARM;
        ARM:        state_nx = WAIT_START;
        WAIT_START: begin
          if (camera_in_progress) state_nx = WAIT_END;
          else if (to_cnt == start_timeout) state_nx = IDLE;
        end
        WAIT_END:   if (!camera_in_progress) state_nx = DONE;
        DONE:       state_nx = IDLE;
        default:    state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      new_capture    <= 1'b0;
      err_timeout    <= 1'b0;
      err_sel        <= 1'b0;
      done_hawk      <= 1'b0;
      done_owl       <= 1'b0;
      frame_cnt_hawk <= '0;
      frame_cnt_owl  <= '0;
      camera_sel     <= 1'b0;
      gnt            <= HAWK;
      last_srv       <= OWL;
      pend_h         <= 1'b0;
      pend_o         <= 1'b0;
      settle_cnt     <= '0;
      to_cnt         <= '0;
    end else begin
      state       <= state_nx;
      busy        <= (state_nx != IDLE);
      new_capture <= (state_nx == ARM);
      err_timeout <= timeout_hit;
      done_hawk   <= done_fire && (gnt == HAWK);
      done_owl    <= done_fire && (gnt == OWL);
      settle_cnt  <= (state == SETTLE) ? settle_cnt + SW'(1) : '0;
      to_cnt      <= (state == WAIT_START) ? to_cnt + 32'd1 : 32'd0;

      if (timeout_hit) err_sel <= gnt;

      if (done_fire) begin
        last_srv <= gnt;
        if (gnt == HAWK) frame_cnt_hawk <= frame_cnt_hawk + CNT_W'(1);
        else             frame_cnt_owl  <= frame_cnt_owl + CNT_W'(1);
      end

      // The select only moves here, so it cannot change under an active capture.
      if (grant_vld) begin
        gnt        <= gnt_pick;
        camera_sel <= gnt_pick;
      end

      // A new request beats a same-cycle grant clear; abort drops everything.
      pend_h <= !abort && (req_hawk || (pend_h && !(grant_vld && gnt_oh[0])));
      pend_o <= !abort && (req_owl  || (pend_o && !(grant_vld && gnt_oh[1])));
    end
  end

endmodule
